// File: rtl/rv32i_pkg.sv
// Shared RV32I constants for the data-memory path: funct3 size codes, major opcodes,
// data-memory FSM state encoding and the store byte-lane helper.
package rv32i_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // funct3[1:0] alone gives the access size; funct3[2] flags an unsigned load
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [6:0] {
    OPC_LOAD  = 7'b0000011,
    OPC_STORE = 7'b0100011
  } opcode_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RESP    = 2'd2
  } mem_state_t;

  function automatic logic [3:0] store_lanes(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_B:    store_lanes = 4'b0001 << off;
      SZ_H:    store_lanes = 4'b0011 << (off & 2'b10);
      default: store_lanes = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the loaded byte/half from a RAM word by address offset and sign/zero extends it.
// Purely combinational; no flow control.
module load_extend
  import rv32i_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  byte_off,
  input  logic [31:0] word,
  output logic [31:0] data
);

  logic [7:0]  b;
  logic [15:0] h;
  logic        sext;

  always_comb begin
    b    = word[7:0];
    h    = byte_off[1] ? word[31:16] : word[15:0];
    sext = ~funct3[2];
    case (byte_off)
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = word[7:0];
    endcase
    case (funct3[1:0])
      SZ_B:    data = {{24{b[7] & sext}}, b};
      SZ_H:    data = {{16{h[15] & sext}}, h};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Load/store front end to a synchronous word RAM: stores take one cycle, loads stall 2 cycles
// (issue + RD_WAIT) and deliver rdata in RESP; illegal/misaligned requests are flagged and dropped.
module data_mem_ctrl
  import rv32i_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [2:0]        funct3,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              stall,
  output logic              misaligned,
  output logic              err,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  mem_state_t  state, state_nx;
  logic [1:0]  size;
  logic        illegal, unaligned;
  logic        ld_go, capture;
  logic [2:0]  ld_f3;
  logic [1:0]  ld_off;
  logic [31:0] ld_data;
  logic        unused_addr_hi;

  // Upper address bits are dropped so accesses wrap modulo the RAM size
  assign unused_addr_hi = ^addr[31:ADDR_W+2];
  assign ram_addr       = addr[ADDR_W+1:2];
  assign size           = funct3[1:0];

  always_comb begin
    case (size)
      SZ_B:    ram_wdata = {4{wdata[7:0]}};
      SZ_H:    ram_wdata = {2{wdata[15:0]}};
      default: ram_wdata = wdata;
    endcase
  end

  always_comb begin
    illegal   = (MemRead && MemWrite)
             || (MemRead  && !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU}))
             || (MemWrite && !(funct3 inside {F3_B, F3_H, F3_W}));
    unaligned = (size == SZ_H && addr[0]) || (size == SZ_W && addr[1:0] != 2'b00);
  end

  always_comb begin
    state_nx   = state;
    ram_en     = 1'b0;
    ram_we     = 4'b0000;
    stall      = 1'b0;
    misaligned = 1'b0;
    err        = 1'b0;
    ld_go      = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        // Requests are gated by rst so a reset cycle can never issue a write
        if (!rst && (MemRead || MemWrite)) begin
          if (illegal) begin
            err = 1'b1;
          end else if (unaligned) begin
            misaligned = 1'b1;
          end else if (MemRead) begin
            ram_en   = 1'b1;
            stall    = 1'b1;
            ld_go    = 1'b1;
            state_nx = RD_WAIT;
          end else begin
            ram_en = 1'b1;
            ram_we = store_lanes(size, addr[1:0]);
          end
        end
      end
      RD_WAIT: begin
        stall    = 1'b1;
        capture  = 1'b1;
        state_nx = RESP;
      end
      RESP: begin
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Size and lane of the load are latched at issue so the extend does not depend on held inputs
  load_extend u_load_extend (
    .funct3   (ld_f3),
    .byte_off (ld_off),
    .word     (ram_rdata),
    .data     (ld_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      rdata  <= '0;
      ld_f3  <= F3_W;
      ld_off <= 2'b00;
    end else begin
      state <= state_nx;
      if (ld_go) begin
        ld_f3  <= funct3;
        ld_off <= addr[1:0];
      end
      if (capture) begin
        rdata <= ld_data;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: byte-addressed reference memory plus per-cycle output compare.
module tb_data_mem_ctrl;

  localparam int ADDR_W = 12;
  localparam int NBYTES = 4 << ADDR_W;

  logic clk = 1'b0, rst = 1'b1, MemRead = 1'b0, MemWrite = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] rdata, ram_wdata, ram_rdata;
  logic        stall, misaligned, err, ram_en;
  logic [3:0]  ram_we;
  logic [ADDR_W-1:0] ram_addr;

  data_mem_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite), .funct3(funct3),
    .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall), .misaligned(misaligned),
    .err(err), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous RAM attached to the DUT: read data one cycle after ram_en
  logic [31:0] ram [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    if (ram_en) begin
      ram_rdata <= ram[ram_addr];
      for (int i = 0; i < 4; i++)
        if (ram_we[i]) ram[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
    end
  end

  // Reference model: flat byte memory and the architecturally visible rdata
  logic [7:0]  gmem [0:NBYTES-1];
  logic [31:0] m_rdata;
  logic        e_en, e_stall, e_mis, e_err;
  logic [3:0]  e_we;
  logic [31:0] e_addr, e_wdata;
  bit          chk_on = 1'b0, chk_ram = 1'b1;
  int          n_pass = 0, n_total = 0;

  bit          cap_en, cap_mis, cap_err;
  logic [3:0]  cap_we;
  logic [31:0] cap_addr, cap_rdata;
  int          cap_stall;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  function automatic bit m_illegal(input bit rd, input bit wr, input logic [2:0] f3);
    if (rd && wr) return 1'b1;
    if (rd) return (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
    if (wr) return (f3 > 3'b010);
    return 1'b0;
  endfunction

  function automatic bit m_misal(input logic [2:0] f3, input logic [31:0] a);
    int n = 1 << f3[1:0];
    return (int'(a[2:0]) % n) != 0;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a);
    int n = 1 << f3[1:0];
    int base = int'(a[ADDR_W+1:0]);
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = gmem[base + i];
    if (!f3[2] && n < 4 && v[8*n-1])
      for (int i = 8*n; i < 32; i++) v[i] = 1'b1;
    return v;
  endfunction

  task automatic m_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                         output logic [3:0] we, output logic [31:0] wd);
    int n = 1 << f3[1:0];
    int off = int'(a[1:0]);
    int wbase = int'(a[ADDR_W+1:0]) - off;
    we = '0;
    wd = '0;
    for (int i = 0; i < 4; i++) begin
      wd[8*i +: 8] = d[8*(i % n) +: 8];
      if (i >= off && i < off + n) begin
        we[i] = 1'b1;
        gmem[wbase + i] = d[8*(i % n) +: 8];
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("stall", 32'(stall), 32'(e_stall));
      chk("misaligned", 32'(misaligned), 32'(e_mis));
      chk("err", 32'(err), 32'(e_err));
      chk("rdata", rdata, m_rdata);
      if (chk_ram) begin
        chk("ram_en", 32'(ram_en), 32'(e_en));
        chk("ram_we", 32'(ram_we), 32'(e_we));
        if (e_en) chk("ram_addr", 32'(ram_addr), e_addr);
        if (e_we != 4'b0000) chk("ram_wdata", ram_wdata, e_wdata);
      end
    end
  end

  task automatic set_idle_exp();
    e_en = 1'b0; e_we = '0; e_stall = 1'b0; e_mis = 1'b0; e_err = 1'b0;
    e_addr = '0; e_wdata = '0; chk_ram = 1'b1;
  endtask

  task automatic clear_caps();
    cap_en = 1'b0; cap_mis = 1'b0; cap_err = 1'b0; cap_we = '0;
    cap_addr = '0; cap_rdata = '0; cap_stall = 0;
  endtask

  task automatic one_cycle();
    @(negedge clk);
    if (ram_en) begin
      cap_en = 1'b1;
      cap_we |= ram_we;
      cap_addr = 32'(ram_addr);
    end
    if (stall) cap_stall++;
    if (misaligned) cap_mis = 1'b1;
    if (err) cap_err = 1'b1;
    cap_rdata = rdata;
    @(posedge clk);
    #1;
  endtask

  // Drives one request (held while stalled) followed by one idle cycle
  task automatic op(input bit rd, input bit wr, input logic [2:0] f3,
                    input logic [31:0] a, input logic [31:0] d);
    logic [3:0]  we;
    logic [31:0] wd;
    clear_caps();
    MemRead = rd; MemWrite = wr; funct3 = f3; addr = a; wdata = d;
    set_idle_exp();
    if (m_illegal(rd, wr, f3)) begin
      e_err = 1'b1;
      one_cycle();
    end else if (m_misal(f3, a)) begin
      e_mis = 1'b1;
      one_cycle();
    end else if (rd) begin
      e_en = 1'b1; e_stall = 1'b1; e_addr = (a >> 2) % (1 << ADDR_W);
      one_cycle();
      e_en = 1'b0; chk_ram = 1'b0;
      one_cycle();
      chk_ram = 1'b1; e_stall = 1'b0;
      m_rdata = m_load(f3, a);
      one_cycle();
    end else begin
      m_store(f3, a, d, we, wd);
      e_en = 1'b1; e_we = we; e_wdata = wd; e_addr = (a >> 2) % (1 << ADDR_W);
      one_cycle();
    end
    MemRead = 1'b0; MemWrite = 1'b0;
    set_idle_exp();
    one_cycle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NBYTES; i++) gmem[i] = 8'h00;
    m_rdata = '0;
    set_idle_exp();
    clear_caps();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_on = 1'b1;
    one_cycle();
    chk("reset_rdata", cap_rdata, 32'h0);

    op(0, 1, 3'b010, 32'h10, 32'hDEADBEEF);
    chk("sw_we", 32'(cap_we), 32'hF);
    chk("sw_addr", cap_addr, 32'h4);
    op(1, 0, 3'b010, 32'h10, 32'h0);
    chk("lw_stall_cycles", 32'(cap_stall), 32'd2);
    chk("lw_rdata", cap_rdata, 32'hDEADBEEF);

    op(0, 1, 3'b000, 32'h13, 32'h80);
    chk("sb_we", 32'(cap_we), 32'h8);
    op(1, 0, 3'b000, 32'h13, 32'h0);
    chk("lb_rdata", cap_rdata, 32'hFFFFFF80);
    op(1, 0, 3'b100, 32'h13, 32'h0);
    chk("lbu_rdata", cap_rdata, 32'h00000080);

    op(1, 0, 3'b001, 32'h21, 32'h0);
    chk("lh_mis_flag", 32'(cap_mis), 32'h1);
    chk("lh_mis_en", 32'(cap_en), 32'h0);
    chk("lh_mis_stall", 32'(cap_stall), 32'h0);
    chk("lh_mis_rdata", cap_rdata, 32'h00000080);

    op(0, 1, 3'b001, 32'h22, 32'h1234ABCD);
    chk("sh_we", 32'(cap_we), 32'hC);
    op(1, 0, 3'b001, 32'h22, 32'h0);
    chk("lh_rdata", cap_rdata, 32'hFFFFABCD);
    op(1, 0, 3'b101, 32'h22, 32'h0);
    chk("lhu_rdata", cap_rdata, 32'h0000ABCD);
    op(1, 0, 3'b001, 32'h10, 32'h0);
    op(1, 0, 3'b100, 32'h11, 32'h0);
    op(1, 0, 3'b000, 32'h12, 32'h0);
    chk("lb_ad_rdata", cap_rdata, 32'hFFFFFFAD);
    op(1, 0, 3'b010, 32'h10, 32'h0);
    chk("lw_merged_rdata", cap_rdata, 32'h80ADBEEF);

    op(1, 0, 3'b101, 32'h23, 32'h0);
    op(0, 1, 3'b010, 32'h12, 32'h55555555);
    op(0, 1, 3'b001, 32'h05, 32'h66666666);
    op(1, 0, 3'b010, 32'h01, 32'h0);

    op(1, 1, 3'b010, 32'h10, 32'h0);
    chk("rdwr_err", 32'(cap_err), 32'h1);
    chk("rdwr_en", 32'(cap_en), 32'h0);
    chk("rdwr_stall", 32'(cap_stall), 32'h0);
    op(1, 0, 3'b011, 32'h10, 32'h0);
    chk("ld011_err", 32'(cap_err), 32'h1);
    chk("ld011_en", 32'(cap_en), 32'h0);
    op(1, 0, 3'b110, 32'h01, 32'h0);
    chk("illegal_over_mis", 32'(cap_mis), 32'h0);
    op(0, 1, 3'b100, 32'h10, 32'h77777777);
    op(0, 1, 3'b101, 32'h11, 32'h77777777);

    op(0, 1, 3'b010, 32'h4010, 32'hCAFEF00D);
    chk("wrap_addr", cap_addr, 32'h4);
    op(1, 0, 3'b010, 32'h10, 32'h0);
    chk("wrap_rdata", cap_rdata, 32'hCAFEF00D);

    // Reset while the load sits in RD_WAIT
    clear_caps();
    set_idle_exp();
    MemRead = 1'b1; funct3 = 3'b010; addr = 32'h10;
    e_en = 1'b1; e_stall = 1'b1; e_addr = 32'h4;
    one_cycle();
    rst = 1'b1;
    chk_on = 1'b0;
    @(negedge clk);
    chk("abort_no_write", 32'(ram_we), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0; MemRead = 1'b0;
    m_rdata = '0;
    set_idle_exp();
    chk_on = 1'b1;
    clear_caps();
    one_cycle();
    chk("abort_rdata", cap_rdata, 32'h0);
    chk("abort_stall", 32'(cap_stall), 32'h0);
    chk("abort_en", 32'(cap_en), 32'h0);

    op(1, 0, 3'b010, 32'h4010, 32'h0);
    chk("post_abort_rdata", cap_rdata, 32'hCAFEF00D);

    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
